// File: rtl/mc_sequencer.sv
// mc_sequencer
//   Multi-cycle control sequencer. Walks each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and decides on which cycle the
//   IR, PC, data memory and register file are allowed to update. ALU
//   control stays in control_unit; this block only owns the timing.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               leave IDLE/HALT and begin fetching
//   halt_req            on a retire cycle, park in HALT instead of fetching
//   opcode, funct3      instruction fields from the IR (used in DECODE only)
//   alu_zero            ALU zero flag, resolves BEQ/BNE in EXEC
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory access complete
//   imem_req, ir_we     fetch request / IR load strobe
//   dmem_req, dmem_we   data request / 1 = store
//   rf_we, wb_sel       register write enable / source (0 ALU, 1 mem, 2 PC+4)
//   pc_en, pc_sel       PC update strobe / source (0 PC+4, 1 PC+imm, 2 ALU)
//   state, busy         current state encoding / in FETCH..WB
//   illegal, timeout    sticky error flags
//   retire, retired_cnt completion pulse / wrapping retire counter
module mc_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        busy,
  output logic        illegal,
  output logic        timeout,
  output logic        retire,
  output logic [31:0] retired_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Instruction class held from DECODE to retire; the IR fields are not
  // trusted after DECODE.
  localparam logic [2:0] C_ALU   = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_STORE = 3'd2;
  localparam logic [2:0] C_BEQ   = 3'd3;
  localparam logic [2:0] C_BNE   = 3'd4;
  localparam logic [2:0] C_JAL   = 3'd5;
  localparam logic [2:0] C_JALR  = 3'd6;

  localparam logic        TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cls_q, cls_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;

  logic        dec_legal;
  logic [2:0]  dec_cls;
  logic        is_branch, is_mem, br_taken, wait_hit;

  // ---------------------------------------------------------------------
  // Opcode/funct3 classification (consumed only in DECODE)
  // ---------------------------------------------------------------------
  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_ALU;
    case (opcode)
      OP_R, OP_IMM, OP_32, OP_IMM32, OP_LUI: dec_cls = C_ALU;
      OP_LOAD:  dec_cls = C_LOAD;
      OP_STORE: dec_cls = C_STORE;
      OP_JAL:   dec_cls = C_JAL;
      OP_JALR:  dec_cls = C_JALR;
      OP_BRANCH: begin
        if (funct3 == 3'b000)      dec_cls = C_BEQ;
        else if (funct3 == 3'b001) dec_cls = C_BNE;
        else                       dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign is_branch = (cls_q == C_BEQ) || (cls_q == C_BNE);
  assign is_mem    = (cls_q == C_LOAD) || (cls_q == C_STORE);
  assign br_taken  = (cls_q == C_BEQ) ? alu_zero : !alu_zero;
  // Last permitted wait cycle; only meaningful while ready is low.
  assign wait_hit  = TO_EN && (wait_q == TO_LAST);

  // ---------------------------------------------------------------------
  // Strobes: decoded from registered state, class and the ready inputs.
  // start/halt_req never reach an output combinationally.
  // ---------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    pc_en    = 1'b0;
    pc_sel   = 2'd0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_en  = 1'b1;
          pc_sel = br_taken ? 2'd1 : 2'd0;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if ((cls_q == C_STORE) && dmem_ready) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_en  = 1'b1;
        retire = 1'b1;
        case (cls_q)
          C_LOAD:  wb_sel = 2'd1;
          C_JAL:   wb_sel = 2'd2;
          C_JALR:  wb_sel = 2'd2;
          default: wb_sel = 2'd0;
        endcase
        case (cls_q)
          C_JAL:   pc_sel = 2'd1;
          C_JALR:  pc_sel = 2'd2;
          default: pc_sel = 2'd0;
        endcase
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        // Ready wins over an expiring wait counter in the same cycle.
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (!is_branch) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls_q == C_LOAD) state_d = S_WB;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      default: ; // WB leaves through retire below; ERROR is absorbing
    endcase

    // Every completion path funnels through here.
    if (retire) begin
      cnt_d   = cnt_q + 32'd1;
      wait_d  = '0;
      state_d = halt_req ? S_HALT : S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q >= S_FETCH) && (state_q <= S_WB);
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer that drives the existing register file, ALU, immediate generator and instruction/data memory ports. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB. On the right cycle it asserts the IR write, PC update, memory request and register-write enables, and it counts retired instructions. It sits between the instruction register and the `control_unit`. `control_unit` still supplies ALU control; this block owns *when* state elements update.

## Interface
- `TIMEOUT`, default 16: maximum cycles to wait for a memory ready in FETCH or MEM. A value of 0 disables the timeout.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  leaves IDLE or HALT and enters FETCH; ignored in all other states.
- `halt_req`  in  1  sampled only on a retire cycle; when 1, the next state is HALT instead of FETCH.
- `opcode`  in  7  `instruction[6:0]` from the IR.
- `funct3`  in  3  `instruction[14:12]` from the IR.
- `alu_zero`  in  1  ALU zero flag.
- `imem_ready`  in  1  instruction memory has valid data this cycle.
- `dmem_ready`  in  1  data memory has completed the access this cycle.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  IR load strobe.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `rf_we`  out  1  register file write enable.
- `wb_sel`  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4.
- `pc_en`  out  1  PC update strobe.
- `pc_sel`  out  2  next PC: 0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR).
- `state`  out  3  current state encoding.
- `busy`  out  1  1 in states FETCH through WB.
- `illegal`  out  1  sticky; set on an unsupported opcode or funct3.
- `timeout`  out  1  sticky; set on a memory timeout.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retired_cnt`  out  32  count of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- **IDLE:** if `start`, go to FETCH.
- **FETCH:** `imem_req`=1 for every cycle spent here.
  - On `imem_ready`: `ir_we`=1 in that same cycle, then go to DECODE.
- **DECODE:** lasts exactly 1 cycle. `opcode` and `funct3` are latched into an internal instruction-class register.
  - Legal opcodes: R 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
  - BRANCH is legal only with `funct3` 000 (BEQ) or 001 (BNE).
  - Illegal opcode or funct3: set `illegal` and go to ERROR. Otherwise go to EXEC.
- **EXEC:** lasts exactly 1 cycle.
  - BRANCH: `pc_en`=1. `pc_sel`=1 if taken, else 0. BEQ is taken when `alu_zero`=1; BNE is taken when `alu_zero`=0. Retire.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- **MEM:** `dmem_req`=1 for every cycle spent here; `dmem_we`=1 for STORE.
  - STORE, on `dmem_ready`: `pc_en`=1, `pc_sel`=0, retire.
  - LOAD, on `dmem_ready`: go to WB.
- **WB:** lasts exactly 1 cycle. `rf_we`=1 and `pc_en`=1, then retire.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, 0 for everything else.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 for everything else.
- **Retire:** `retire`=1 and `retired_cnt` increments, wrapping from 0xFFFFFFFF to 0. Next state is HALT if `halt_req`=1, else FETCH.
- **HALT:** all strobes are 0. `start` returns to FETCH.
- **ERROR:** absorbing state; all strobes are 0. Only `rst` exits it.
- **Timeout:** an internal wait counter clears on entry to FETCH or MEM and increments each cycle without ready.
  - When it reaches `TIMEOUT` and ready is still 0: set `timeout` and go to ERROR.
  - If ready arrives on that same cycle, ready wins.
- All strobes (`imem_req`, `ir_we`, `dmem_req`, `dmem_we`, `rf_we`, `pc_en`, `retire`) are 0 in any state not listed above as asserting them.

## Timing
- **Reset (`rst`=0):** asynchronous.
  - `state`=IDLE.
  - All strobes=0; `wb_sel`=0, `pc_sel`=0.
  - `busy`=0, `illegal`=0, `timeout`=0.
  - `retired_cnt`=0; wait counter=0.
- **Reset mid-instruction:** abort immediately. No partial `rf_we` or `pc_en` is produced after `rst` falls.
- **Release:** the first rising edge after `rst` goes high acts normally. `start` high on that edge moves to FETCH.
- **Output derivation:** outputs are combinational decodes of the registered state, the class register and the ready inputs. No output depends on `start` or `halt_req` in the same cycle.
- **Latency with zero-wait memories** (ready in the first request cycle):
  - ALU-class: 4 cycles (F, D, E, W).
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- **Wait states:** each cycle of ready=0 adds one cycle.
- **Request hold:** `imem_req` and `dmem_req` stay high until ready. Ready arriving while no request is active is ignored.

## Test plan
- Reset, then `start`=1 for 1 cycle, ADDI x14,x0,-1 (0xFFF00713) with `imem_ready`=1 -> states 1,2,3,5. `rf_we`=1 and `wb_sel`=0 in WB. `retire` pulses once; `retired_cnt`=1.
- LW with `dmem_ready` delayed 3 cycles -> `dmem_req` high for 4 cycles with `dmem_we`=0. WB has `wb_sel`=1. Total 8 cycles.
- BEQ with `alu_zero`=1 -> `pc_en`=1 and `pc_sel`=1 in EXEC, `rf_we` never asserts. BNE with `alu_zero`=1 -> `pc_sel`=0.
- JALR -> WB has `wb_sel`=2 and `pc_sel`=2. `halt_req`=1 on that cycle -> HALT and `busy`=0. `start` -> FETCH.
- `opcode`=0x7F -> `illegal`=1 and `state`=7. Further `start` pulses have no effect. `rst` pulse clears to IDLE.
- `TIMEOUT`=4 with `imem_ready` held 0 -> `timeout`=1 and ERROR after 4 FETCH cycles. A repeat run with ready on cycle 4 -> reaches DECODE instead.
